// File: rtl/riscv_defines.sv
// Shared RISC-V widths, opcode constants and prefetch helper types.
// Latency: none (declarations only).
// Backpressure: not applicable.
package riscv_defines;

  localparam int RISCV_WORD_WIDTH = 32;
  localparam int RISCV_ADDR_WIDTH = 32;

  // Low two opcode bits of every 32-bit instruction; anything else is compressed.
  localparam logic [1:0] RISCV_OPC_32BIT = 2'b11;

  typedef logic [RISCV_ADDR_WIDTH-1:0] riscv_addr_t;
  typedef logic [RISCV_WORD_WIDTH-1:0] riscv_word_t;

  // Decoded view of the instruction at the head of the fetch FIFO.
  typedef struct packed {
    logic        valid;        // a complete instruction is available
    logic        len4;         // 1: 32-bit instruction, 0: compressed
    logic        pop;          // retiring it frees the head word
    logic        offset_next;  // halfword offset after retirement
    riscv_word_t data;         // realigned instruction
  } head_t;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != RISCV_OPC_32BIT;
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Word FIFO for fetched instruction words with flush; exposes the two oldest entries.
// Latency: a pushed word is visible at entry0/entry1 the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens the same cycle.
module riscv_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       entry0,
  output logic [WIDTH-1:0]       entry1,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL    = DEPTH[AW:0];
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify push/pop against occupancy so pointers never over/underrun.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL) || do_pop);
  end

  assign entry0 = mem[rd_ptr];
  assign entry1 = mem[rd_ptr + AW'(1)];

  // Pointer and occupancy bookkeeping; flush empties in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/riscv_prefetch_buffer.sv
// Instruction prefetcher: fetches words ahead into a FIFO and presents aligned instructions (RISCV_COMPRESSED_EN adds 16-bit realignment).
// Latency: redirect at cycle N -> memory request at N+1 -> instr_valid_o at N+2 with zero-wait memory.
// Backpressure: stops requesting when the FIFO is full; a stalled memory request is held until accepted.
module riscv_prefetch_buffer
  import riscv_defines::*;
#(
  parameter int          DEPTH     = 4,
  parameter riscv_addr_t BOOT_ADDR = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [RISCV_ADDR_WIDTH-1:0] target_addr_i,
  input  logic                        target_valid_i,
  output logic [RISCV_WORD_WIDTH-1:0] instr_o,
  output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
  output logic                        instr_valid_o,
  input  logic                        instr_ready_i,
  output logic                        imem_valid_o,
  input  logic                        imem_ready_i,
  output logic [RISCV_ADDR_WIDTH-1:0] imem_addr_o,
  output logic [RISCV_WORD_WIDTH-1:0] imem_wdata_o,
  output logic [3:0]                  imem_we_o,
  input  logic [RISCV_WORD_WIDTH-1:0] imem_rdata_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL    = DEPTH[CW-1:0];
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Fetch side state
  riscv_addr_t fetch_ptr;     // address of the current/next memory request
  riscv_addr_t redirect_ptr;  // target remembered while a stale request drains
  logic        pending;       // request presented last cycle but not accepted
  logic        discard;       // the pending request's data belongs to an old stream

  // Instruction side state
  riscv_addr_t instr_addr_q;

  logic          fire;
  logic          push;
  logic          retire;
  logic          fifo_pop;
  riscv_addr_t   target_word;
  riscv_addr_t   target_instr;
  riscv_word_t   entry0;
  riscv_word_t   entry1;
  logic [CW-1:0] count;
  head_t         head;
  logic          unused_bits;

  assign target_word = {target_addr_i[RISCV_ADDR_WIDTH-1:2], 2'b00};

`ifdef RISCV_COMPRESSED_EN
  logic offset_q;  // 1: head instruction starts in the upper halfword of entry0

  assign target_instr = target_addr_i;
  assign unused_bits  = ^entry1[31:16];

  // Realign the head instruction from one or two FIFO words.
  always_comb begin
    head = '0;
    if (!offset_q) begin
      head.valid = (count != '0);
      if (is_compressed(entry0[15:0])) begin
        head.data        = {16'h0000, entry0[15:0]};
        head.len4        = 1'b0;
        head.pop         = 1'b0;
        head.offset_next = 1'b1;
      end else begin
        head.data        = entry0;
        head.len4        = 1'b1;
        head.pop         = 1'b1;
        head.offset_next = 1'b0;
      end
    end else if (is_compressed(entry0[31:16])) begin
      head.valid       = (count != '0);
      head.data        = {16'h0000, entry0[31:16]};
      head.len4        = 1'b0;
      head.pop         = 1'b1;
      head.offset_next = 1'b0;
    end else begin
      // 32-bit instruction straddling two words needs both present.
      head.valid       = (count > CNT_ONE);
      head.data        = {entry1[15:0], entry0[31:16]};
      head.len4        = 1'b1;
      head.pop         = 1'b1;
      head.offset_next = 1'b1;
    end
  end

  // Halfword offset tracks where the head instruction starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q <= 1'b0;
    end else if (target_valid_i) begin
      offset_q <= target_addr_i[1];
    end else if (retire) begin
      offset_q <= head.offset_next;
    end
  end
`else
  assign target_instr = target_word;
  assign unused_bits  = ^{entry1, target_addr_i[1:0], head.offset_next};

  // Every instruction is a full aligned word.
  always_comb begin
    head             = '0;
    head.valid       = (count != '0);
    head.data        = entry0;
    head.len4        = 1'b1;
    head.pop         = 1'b1;
    head.offset_next = 1'b0;
  end
`endif

  // Request while there is room (occupancy sampled before any pop), or keep a stalled one alive.
  always_comb begin
    imem_valid_o = !rst && (pending || ((count != FULL) && !target_valid_i));
    fire         = imem_valid_o && imem_ready_i;
    push         = fire && !discard && !target_valid_i;
    retire       = instr_valid_o && instr_ready_i && !target_valid_i;
    fifo_pop     = retire && head.pop;
  end

  assign imem_addr_o   = fetch_ptr;
  assign imem_wdata_o  = '0;
  assign imem_we_o     = 4'b0000;
  assign instr_valid_o = !rst && head.valid;
  assign instr_o       = instr_valid_o ? head.data : '0;
  assign instr_addr_o  = rst ? BOOT_ADDR : instr_addr_q;

  // Fetch pointer, stall tracking and stale-data discard across redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_ptr    <= BOOT_ADDR;
      redirect_ptr <= BOOT_ADDR;
      pending      <= 1'b0;
      discard      <= 1'b0;
    end else begin
      pending <= imem_valid_o && !imem_ready_i;
      if (target_valid_i) begin
        if (imem_valid_o && !imem_ready_i) begin
          // Stalled request must finish at its old address; remember where to go next.
          discard      <= 1'b1;
          redirect_ptr <= target_word;
        end else begin
          fetch_ptr <= target_word;
          discard   <= 1'b0;
        end
      end else if (fire) begin
        if (discard) begin
          fetch_ptr <= redirect_ptr;
          discard   <= 1'b0;
        end else begin
          fetch_ptr <= fetch_ptr + 32'd4;
        end
      end
    end
  end

  // Address of the head instruction; redirect wins over retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_addr_q <= BOOT_ADDR;
    end else if (target_valid_i) begin
      instr_addr_q <= target_instr;
    end else if (retire) begin
      instr_addr_q <= instr_addr_q + (head.len4 ? 32'd4 : 32'd2);
    end
  end

  riscv_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RISCV_WORD_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (target_valid_i),
    .push      (push),
    .push_data (imem_rdata_i),
    .pop       (fifo_pop),
    .entry0    (entry0),
    .entry1    (entry1),
    .count     (count)
  );

endmodule
